// File: rtl/id_wrport_arb.sv
// id_wrport_arb: shares one register-file write port between pipeline writebacks and buffered multi-cycle results.
// Latency: one cycle from grant to o_wrSig/o_wrReg/o_wrData; a buffered entry pops no earlier than the cycle after its push.
// Backpressure: multi-cycle unit held off by o_muReady when the buffer is full; pipeline asked to withhold writeback for one cycle when the head ages out.
module id_wrport_arb #(
  parameter int FIFO_DEPTH = 2,
  parameter int AGE_LIMIT  = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wbValid,
  input  logic [4:0]  i_wbReg,
  input  logic [31:0] i_wbData,
  input  logic        i_muValid,
  input  logic [4:0]  i_muReg,
  input  logic [31:0] i_muData,
  output logic        o_muReady,
  output logic        o_wrSig,
  output logic [4:0]  o_wrReg,
  output logic [31:0] o_wrData,
  output logic        o_wbStall,
  output logic [31:0] o_pending,
  output logic [3:0]  o_fifoCount,
  output logic        o_err
);

  localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0]   LAST    = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]      DEPTH_C = 4'(FIFO_DEPTH);
  localparam logic [7:0]      AGE_MAX = 8'(AGE_LIMIT);

  logic [4:0]            buf_reg [FIFO_DEPTH];
  logic [31:0]           buf_dat [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] buf_vld;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [3:0]            count;
  logic [7:0]            age;
  logic [7:0]            age_nxt;
  logic [31:0]           pend;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  wb_req;
  logic                  grant_wb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count == 4'd0);
  assign o_fifoCount = count;
  // Ready looks only at registered occupancy, so a same-cycle pop never opens a full buffer.
  assign o_muReady   = (count < DEPTH_C) && !i_reset;
  // Writes to x0 are accepted but never stored.
  assign push        = i_muValid && o_muReady && (i_muReg != 5'd0);
  assign wb_req      = i_wbValid && (i_wbReg != 5'd0);
  assign o_pending   = pend;

  // Arbitration: stall cycle forces a pop, otherwise the pipeline wins, otherwise drain the buffer.
  always_comb begin
    pop      = 1'b0;
    grant_wb = 1'b0;
    if (!i_reset) begin
      if (o_wbStall && !empty) pop = 1'b1;
      else if (wb_req)         grant_wb = 1'b1;
      else if (!empty)         pop = 1'b1;
    end
  end

  // Head age: cleared when the head leaves or nothing is buffered, else counts up to the limit.
  always_comb begin
    age_nxt = age;
    if (pop || empty)        age_nxt = 8'd0;
    else if (age >= AGE_MAX) age_nxt = AGE_MAX;
    else                     age_nxt = age + 8'd1;
  end

  // Pending-register mask built from stored entries only, so duplicates stay visible until the last one pops.
  always_comb begin
    pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (buf_vld[i]) pend = pend | (32'd1 << buf_reg[i]);
    end
  end

  // Entry payload storage; contents are meaningless unless the matching valid bit is set.
  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_reg[wr_ptr] <= i_muReg;
      buf_dat[wr_ptr] <= i_muData;
    end
  end

  // Buffer bookkeeping, age/stall tracking, registered write port and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_vld   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= 4'd0;
      age       <= 8'd0;
      o_wbStall <= 1'b0;
      o_wrSig   <= 1'b0;
      o_wrReg   <= 5'd0;
      o_wrData  <= 32'd0;
      o_err     <= 1'b0;
    end else begin
      // Push and pop never touch the same slot: pop needs an entry, push needs a free slot.
      if (push) begin
        buf_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        buf_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end
      if (push && !pop)      count <= count + 4'd1;
      else if (pop && !push) count <= count - 4'd1;

      age       <= age_nxt;
      // One-cycle pulse on the edge where the head first hits the age limit.
      o_wbStall <= (age_nxt == AGE_MAX) && (age != AGE_MAX);

      if (grant_wb) begin
        o_wrSig  <= 1'b1;
        o_wrReg  <= i_wbReg;
        o_wrData <= i_wbData;
      end else if (pop) begin
        o_wrSig  <= 1'b1;
        o_wrReg  <= buf_reg[rd_ptr];
        o_wrData <= buf_dat[rd_ptr];
      end else begin
        o_wrSig  <= 1'b0;
      end

      // The pipeline ignored the stall request; its write is lost.
      if (o_wbStall && wb_req) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_wrport_arb.sv
module tb_id_wrport_arb;

  localparam int DEPTH = 2;
  localparam int AGE   = 8;

  logic        i_clk;
  logic        i_reset;
  logic        i_wbValid;
  logic [4:0]  i_wbReg;
  logic [31:0] i_wbData;
  logic        i_muValid;
  logic [4:0]  i_muReg;
  logic [31:0] i_muData;
  logic        o_muReady;
  logic        o_wrSig;
  logic [4:0]  o_wrReg;
  logic [31:0] o_wrData;
  logic        o_wbStall;
  logic [31:0] o_pending;
  logic [3:0]  o_fifoCount;
  logic        o_err;

  id_wrport_arb #(.FIFO_DEPTH(DEPTH), .AGE_LIMIT(AGE)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wbValid(i_wbValid), .i_wbReg(i_wbReg), .i_wbData(i_wbData),
    .i_muValid(i_muValid), .i_muReg(i_muReg), .i_muData(i_muData),
    .o_muReady(o_muReady), .o_wrSig(o_wrSig), .o_wrReg(o_wrReg), .o_wrData(o_wrData),
    .o_wbStall(o_wbStall), .o_pending(o_pending), .o_fifoCount(o_fifoCount), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered writes plus the visible write-port state.
  typedef struct packed { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  int          m_age   = 0;
  bit          m_stall = 0;
  bit          m_err   = 0;
  bit          m_wsig  = 0;
  logic [4:0]  m_wreg  = '0;
  logic [31:0] m_wdat  = '0;

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (mq[i]) p = p | (32'd1 << mq[i].r);
    return p;
  endfunction

  // Drive one cycle of inputs, compare all outputs mid-cycle, then advance the model and the clock.
  task automatic step(input logic rst, input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md);
    ent_t e;
    bit   popped;
    bit   was_empty;
    bit   ready;
    int   old_age;
    i_reset = rst; i_wbValid = wv; i_wbReg = wr; i_wbData = wd;
    i_muValid = mv; i_muReg = mr; i_muData = md;
    #3;
    ready = (mq.size() < DEPTH) && !rst;
    chk("wrSig",   32'(o_wrSig),     32'(m_wsig));
    chk("wrReg",   32'(o_wrReg),     32'(m_wreg));
    chk("wrData",  o_wrData,         m_wdat);
    chk("wbStall", 32'(o_wbStall),   32'(m_stall));
    chk("pending", o_pending,        m_pend());
    chk("count",   32'(o_fifoCount), mq.size());
    chk("err",     32'(o_err),       32'(m_err));
    chk("muReady", 32'(o_muReady),   32'(ready));
    if (rst) begin
      mq.delete();
      m_age = 0; m_stall = 0; m_err = 0; m_wsig = 0; m_wreg = '0; m_wdat = '0;
    end else begin
      was_empty = (mq.size() == 0);
      popped = 0;
      if (m_stall && wv && wr != 0) m_err = 1;
      if (m_stall && !was_empty) popped = 1;
      else if (wv && wr != 0) begin m_wsig = 1; m_wreg = wr; m_wdat = wd; end
      else if (!was_empty) popped = 1;
      else m_wsig = 0;
      if (popped) begin
        e = mq.pop_front();
        m_wsig = 1; m_wreg = e.r; m_wdat = e.d;
      end
      old_age = m_age;
      if (popped || was_empty) m_age = 0;
      else m_age = (m_age + 1 > AGE) ? AGE : m_age + 1;
      m_stall = (m_age == AGE) && (old_age != AGE);
      if (mv && ready && mr != 0) begin
        e.r = mr; e.d = md;
        mq.push_back(e);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [4:0] rr;
    i_clk = 0;
    i_reset = 1; i_wbValid = 0; i_wbReg = 0; i_wbData = 0;
    i_muValid = 0; i_muReg = 0; i_muData = 0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_wrSig",   32'(o_wrSig), 0);
    chk("rst_wrReg",   32'(o_wrReg), 0);
    chk("rst_wrData",  o_wrData, 0);
    chk("rst_stall",   32'(o_wbStall), 0);
    chk("rst_pending", o_pending, 0);
    chk("rst_count",   32'(o_fifoCount), 0);
    chk("rst_err",     32'(o_err), 0);
    chk("rst_muReady", 32'(o_muReady), 0);

    // Pipeline-only write.
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    chk("wb_sig", 32'(o_wrSig), 1);
    chk("wb_reg", 32'(o_wrReg), 5);
    chk("wb_dat", o_wrData, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wb_idle", 32'(o_wrSig), 0);

    // Multi-cycle result through an empty buffer.
    step(0, 0, 0, 0, 1, 5'd7, 32'h12345678);
    chk("mu_pend", o_pending, 32'h80);
    chk("mu_cnt1", 32'(o_fifoCount), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("mu_sig",  32'(o_wrSig), 1);
    chk("mu_reg",  32'(o_wrReg), 7);
    chk("mu_dat",  o_wrData, 32'h12345678);
    chk("mu_pend0", o_pending, 0);
    chk("mu_cnt0", 32'(o_fifoCount), 0);

    // x0 targets from both sources are dropped.
    step(0, 1, 5'd0, 32'h1111, 1, 5'd0, 32'h2222);
    chk("x0_sig", 32'(o_wrSig), 0);
    chk("x0_cnt", 32'(o_fifoCount), 0);
    chk("x0_rdy", 32'(o_muReady), 1);

    // Fill while the pipeline hogs the port until the head ages out.
    for (int i = 0; i < 9; i++)
      step(0, 1, 5'd10, 32'(i), (i < 2), (i == 0) ? 5'd3 : 5'd4, (i == 0) ? 32'hA0A0 : 32'hB0B0);
    chk("age_stall", 32'(o_wbStall), 1);
    chk("age_cnt",   32'(o_fifoCount), 2);
    chk("age_rdy",   32'(o_muReady), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("age_wsig",  32'(o_wrSig), 1);
    chk("age_wreg",  32'(o_wrReg), 3);
    chk("age_stl0",  32'(o_wbStall), 0);

    // Pipeline ignores the stall: head still written, error latched.
    for (int i = 0; i < 8; i++) step(0, 1, 5'd11, 32'(i), 0, 0, 0);
    chk("viol_stall", 32'(o_wbStall), 1);
    step(0, 1, 5'd9, 32'h9999, 0, 0, 0);
    chk("viol_err",  32'(o_err), 1);
    chk("viol_reg",  32'(o_wrReg), 4);
    chk("viol_dat",  o_wrData, 32'hB0B0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("viol_sticky", 32'(o_err), 1);

    // Reset with two entries buffered.
    step(0, 1, 5'd12, 1, 1, 5'd20, 32'hC0C0);
    step(0, 1, 5'd12, 2, 1, 5'd21, 32'hD0D0);
    chk("mid_cnt", 32'(o_fifoCount), 2);
    step(1, 1, 5'd6, 3, 0, 0, 0);
    i_reset = 0; i_wbValid = 0; i_muValid = 0;
    #1;
    chk("mid_cnt0", 32'(o_fifoCount), 0);
    chk("mid_pend", o_pending, 0);
    chk("mid_sig",  32'(o_wrSig), 0);
    chk("mid_err",  32'(o_err), 0);
    chk("mid_rdy",  32'(o_muReady), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6), rr, $urandom,
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_wrport_arb.md
ID_WRPORT_ARB -- requirements
Module: id_wrport_arb

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 2, secondary-source buffer entries (legal 2..8); AGE_LIMIT, default 8, wait cycles before forced drain (legal 2..255).
REQ-002 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_wbValid  in  1  pipeline writeback request; no backpressure.
REQ-005 i_wbReg  in  5  pipeline destination register.
REQ-006 i_wbData  in  32  pipeline write data.
REQ-007 i_muValid  in  1  multi-cycle unit result valid.
REQ-008 i_muReg  in  5  multi-cycle unit destination register.
REQ-009 i_muData  in  32  multi-cycle unit write data.
REQ-010 o_muReady  out  1  buffer can accept a multi-cycle result.
REQ-011 o_wrSig  out  1  register-file write enable, registered.
REQ-012 o_wrReg  out  5  register-file write address, registered.
REQ-013 o_wrData  out  32  register-file write data, registered.
REQ-014 o_wbStall  out  1  one-cycle request that the pipeline withhold writeback, registered.
REQ-015 o_pending  out  32  bit r set while any buffered entry targets register r.
REQ-016 o_fifoCount  out  4  buffered entry count.
REQ-017 o_err  out  1  sticky protocol-violation flag.

Function
REQ-018 A multi-cycle result SHALL be accepted when i_muValid && o_muReady; an accepted result with i_muReg==0 SHALL be discarded, not buffered.
REQ-019 o_muReady SHALL equal (o_fifoCount < FIFO_DEPTH) && !i_reset; a pop in the same cycle SHALL NOT raise ready when full (no pass-through).
REQ-020 Buffer SHALL be FIFO order with wrapping read/write pointers; no bypass: an entry pushed at edge N is poppable from cycle N onward, earliest write-port output at edge N+1 after pop.
REQ-021 Grant per cycle: when stall cycle active (o_wbStall==1) and buffer non-empty, pop head; else if i_wbValid && i_wbReg!=0, grant pipeline; else if buffer non-empty, pop head; else no write.
REQ-022 Pipeline requests with i_wbReg==0 SHALL produce no write and SHALL not block a pop that cycle.
REQ-023 Granted request in cycle N SHALL appear on o_wrSig/o_wrReg/o_wrData after edge N (latency 1); with no grant, o_wrSig=0 and o_wrReg/o_wrData hold previous values.
REQ-024 Age counter (8 bits): cleared on pop or when buffer empty; otherwise increments each cycle head is not popped, saturating at AGE_LIMIT.
REQ-025 o_wbStall SHALL be 1 for exactly one cycle following the edge at which age reached AGE_LIMIT; age SHALL clear on that stall-cycle pop.
REQ-026 i_wbValid && i_wbReg!=0 during a stall cycle SHALL set o_err; pipeline request is dropped, head is popped.
REQ-027 o_pending SHALL be the OR of one-hot decodes of all valid entries, derived from registered FIFO state; duplicate targets keep the bit set until the last such entry pops.
REQ-028 Simultaneous push and pop SHALL leave o_fifoCount unchanged; push with count==FIFO_DEPTH is impossible by REQ-019.
REQ-029 Write ordering hazards between sources SHALL be resolved by the pipeline using o_pending; block performs no data forwarding.

Reset
REQ-030 On i_reset at an edge: pointers, count, age cleared; o_wrSig=0, o_wrReg=0, o_wrData=0, o_wbStall=0, o_pending=0, o_err=0; in-flight buffered entries discarded.
REQ-031 Reset asserted mid-drain SHALL suppress any grant in that cycle; first write after release at the edge following the first post-reset grant.

Verification
REQ-032 Pipeline only: i_wbValid=1, reg 5, data 0xDEADBEEF at cycle 0 -> o_wrSig=1, o_wrReg=5, o_wrData=0xDEADBEEF in cycle 1; cycle 2 o_wrSig=0.
REQ-033 MU only, buffer empty: push reg 7 data 0x12345678 at cycle 0 -> o_pending[7]=1 in cycle 1, write appears cycle 2, o_pending=0 and o_fifoCount=0 in cycle 2.
REQ-034 Fill: DEPTH=2, pipeline busy every cycle, push regs 3,4 -> o_muReady=0 with count 2; after AGE_LIMIT=8 blocked cycles o_wbStall=1 one cycle, reg 3 written next edge.
REQ-035 x0: i_wbReg=0 and i_muReg=0 accepted -> no o_wrSig, o_fifoCount stays 0, o_muReady stays 1.
REQ-036 Stall violation: i_wbValid=1 reg 9 during o_wbStall=1 -> o_err=1 and remains 1 until reset; buffered head written instead.
REQ-037 Reset mid-operation: count 2, assert i_reset one cycle -> next cycle o_fifoCount=0, o_pending=0, o_wrSig=0, o_err=0, o_muReady=1.
